// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants used by both the AXIS master and the receiving slave FIFO.
package axis_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
endpackage

// File: rtl/axis_s_fifo_if.sv
// AXI-Stream handshake bundle; the master drives payload and valid, the slave returns ready.
interface axis_s_fifo_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is visible combinationally while level is non-zero.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   level_next,
  output logic              empty
);
  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full, do_push, do_pop;

  assign full    = (level_q == LevelFull);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + (ADDR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data    = mem[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;
endmodule

// File: rtl/axis_s_fifo.sv
// AXIS slave receiver: buffers beats in a FWFT FIFO and tracks packet completion statistics.
module axis_s_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W = axis_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  axis_s_fifo_if.slave      axis,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   level,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  pkt_len,
  output logic              err_underflow
);
  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);

  logic              tready_q, tready_d;
  logic              pkt_done_q, pkt_done_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]  pkt_len_q, pkt_len_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              push, pop, empty;
  logic [ADDR_W:0]   level_next;

  assign push     = axis.tvalid & tready_q;
  assign rd_valid = ~empty;
  assign pop      = rd_en & rd_valid;

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .push       (push),
    .wr_data    ({axis.tlast, axis.tdata}),
    .pop        (pop),
    .rd_data    ({rd_last, rd_data}),
    .level      (level),
    .level_next (level_next),
    .empty      (empty)
  );

  always_comb begin
    tready_d    = (level_next != LevelFull);
    pkt_done_d  = 1'b0;
    pkt_count_d = pkt_count_q;
    pkt_len_d   = pkt_len_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q | (rd_en & ~rd_valid);
    if (push) begin
      if (axis.tlast) begin
        pkt_len_d   = beat_cnt_q + CNT_W'(1);
        pkt_count_d = pkt_count_q + CNT_W'(1);
        beat_cnt_d  = '0;
        pkt_done_d  = 1'b1;
      end else begin
        beat_cnt_d  = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tready_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      pkt_len_q   <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      tready_q    <= tready_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
      pkt_len_q   <= pkt_len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign axis.tready   = tready_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_count     = pkt_count_q;
  assign pkt_len       = pkt_len_q;
  assign err_underflow = err_q;
endmodule

// File: doc/axis_s_fifo.md
Name: axis_s_fifo

Overview:
AXI-Stream slave (receiver) that pairs with the team's AXIS master. It accepts beats on tvalid/tready/tdata/tlast and buffers them in a small first-word-fall-through FIFO. Words are delivered to a user read port, and the block reports packet-completion status. It sits at the receiving end of any AXIS link in the design and absorbs producer bursts while the user side drains at its own pace.

Parameters:
DATA_W, 32, width of tdata and rd_data
DEPTH, 4, FIFO entries; power of 2, >= 2
ADDR_W, log2(DEPTH), derived localparam; not overridable

Ports:
aclk  input  1  clock, all logic on rising edge
areset_n  input  1  reset, asynchronous, active-low
tvalid  input  1  AXIS beat valid from master
tready  output  1  AXIS ready to master, registered
tdata  input  DATA_W  AXIS payload
tlast  input  1  AXIS end-of-packet marker
rd_en  input  1  user pop request
rd_valid  output  1  FIFO head valid (level != 0)
rd_data  output  DATA_W  FIFO head data, show-ahead
rd_last  output  1  tlast stored with head word
level  output  ADDR_W+1  current occupancy, 0..DEPTH
pkt_done  output  1  one-cycle pulse, registered, per accepted tlast beat
pkt_count  output  16  accepted packets, wraps 0xFFFF->0x0000
pkt_len  output  16  beat count of last completed packet, latched
err_underflow  output  1  sticky; rd_en seen while rd_valid=0

Behaviour:
- Reset (areset_n low, async): tready=0, level=0, rd_valid=0, pkt_done=0, pkt_count=0, pkt_len=0, err_underflow=0. Pointers and the beat counter are cleared. Memory contents are not reset, and rd_data/rd_last are don't-care while rd_valid=0.
- Push = tvalid & tready, sampled on rising aclk. {tlast, tdata} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Pop = rd_en & rd_valid. rd_ptr increments mod DEPTH.
- level_next = level + push - pop. Simultaneous push and pop leaves level unchanged.
- tready is a register: tready <= (level_next != DEPTH). It is 1 on the first rising aclk after reset release. It never depends combinationally on tvalid.
- When full, tready=0. A push at level DEPTH-1 with no pop drives tready=0 in the next cycle. A push with a pop at DEPTH-1 keeps tready=1.
- Master-side protocol: tdata/tlast must stay stable while tvalid=1 and tready=0. The block does not check this.
- Latency: a word pushed at edge N is visible on rd_valid/rd_data/rd_last after edge N (1 cycle), including when the FIFO was empty. There is no bypass path.
- rd_data = mem[rd_ptr] combinationally, and rd_valid = (level != 0).
- rd_en while empty: no state change except err_underflow <= 1. The flag clears only on reset.
- Packet tracking:
  - beat_cnt (16b) increments on each push.
  - On a push with tlast=1: pkt_len <= beat_cnt+1, beat_cnt <= 0, pkt_count <= pkt_count+1, pkt_done <= 1 for exactly one cycle.
  - All counters wrap mod 2^16.
  - Back-to-back tlast beats give consecutive pkt_done pulses.
- Reset mid-packet: the partial packet is discarded, and beat_cnt restarts at 0.
- There is no state machine beyond the FIFO pointers and counters. Order is strictly FIFO.

Decomposition:
- Shared package axis_pkg holds DATA_W default (32) and CNT_W (16) for pkt_count/pkt_len/beat_cnt. The master also uses these.
- One sub-module, sync_fifo_fwft, owns storage, pointers, level and full/empty. It has parameters DATA_W+1 (data plus last bit) and DEPTH.
- axis_s_fifo wraps it and adds the registered tready, packet counters and underflow flag.

Test Plan:
1. Assert areset_n=0 mid-cycle -> tready=0, rd_valid=0, level=0, pkt_count=0 immediately (async). Release -> tready=1 after the first rising aclk.
2. Single beat tdata=0xDEADBEEF, tlast=1, rd_en=0 -> next cycle rd_valid=1, rd_data=0xDEADBEEF, rd_last=1, level=1, pkt_done high for 1 cycle, pkt_count=1, pkt_len=1.
3. DEPTH=4, rd_en=0, tvalid held with 0x1,0x2,0x3,0x4,0x5 -> four beats accepted, tready=0 in the cycle after the 4th, level=4, 0x5 held. Pulse rd_en once -> rd_data 0x1 popped, tready=1 next cycle, 0x5 accepted, rd_data=0x2.
4. At level=2, push and pop on the same edge -> level stays 2. Reads return the exact write order with no loss or duplication.
5. rd_en=1 while level=0 -> level, pointers and rd_valid unchanged, err_underflow=1 and stays 1 through later traffic until reset.
6. Push 2 beats of a 3-beat packet, pulse areset_n low, then push a fresh 3-beat packet (last on 3rd) -> pkt_len=3, pkt_count=1, rd_data shows only the new packet's words.
